// File: rtl/arm_multicycle_ctrl.sv
// arm_multicycle_ctrl: main controller for the multicycle ARM datapath.
// Sequences FETCH/DECODE/EXECUTE, holds the NZCV flag register and resolves
// conditional execution in DECODE. The latched result gates every architectural
// write (register, memory, PC, flags) in the states that follow.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-low reset
//   Cond, Op, Funct  instruction fields IR[31:28], IR[27:26], IR[25:20]
//   Rd               destination register IR[15:12]
//   ALUFlags         {N,Z,C,V} produced by the ALU this cycle
//   Flags            registered {N,Z,C,V}
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc   datapath selects
module arm_multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic [3:0] Flags,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc
);

   localparam logic [3:0] FETCH  = 4'd0;
   localparam logic [3:0] DECODE = 4'd1;
   localparam logic [3:0] MEMADR = 4'd2;
   localparam logic [3:0] MEMRD  = 4'd3;
   localparam logic [3:0] MEMWB  = 4'd4;
   localparam logic [3:0] MEMWR  = 4'd5;
   localparam logic [3:0] EXECR  = 4'd6;
   localparam logic [3:0] EXECI  = 4'd7;
   localparam logic [3:0] ALUWB  = 4'd8;
   localparam logic [3:0] BRANCH = 4'd9;
   localparam logic [3:0] TRAP   = 4'd10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   logic [3:0] state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       cond_ok_q, cond_ok_d;

   logic       cond_ex, ge;
   logic [3:0] cmd;
   logic       reg_w, mem_w, branch, alu_op, no_write, pcs;
   logic [1:0] flag_w;

   assign cmd = Funct[4:1];
   assign ge  = (flags_q[3] == flags_q[0]);

   always_comb begin
      cond_ex = 1'b0;
      case (Cond)
         4'b0000: cond_ex = flags_q[2];
         4'b0001: cond_ex = ~flags_q[2];
         4'b0010: cond_ex = flags_q[1];
         4'b0011: cond_ex = ~flags_q[1];
         4'b0100: cond_ex = flags_q[3];
         4'b0101: cond_ex = ~flags_q[3];
         4'b0110: cond_ex = flags_q[0];
         4'b0111: cond_ex = ~flags_q[0];
         4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
         4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
         4'b1010: cond_ex = ge;
         4'b1011: cond_ex = ~ge;
         4'b1100: cond_ex = ~flags_q[2] & ge;
         4'b1101: cond_ex = ~(~flags_q[2] & ge);
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? EXECI : EXECR;
               2'b01:   state_d = MEMADR;
               2'b10:   state_d = BRANCH;
               default: state_d = TRAP;
            endcase
         end
         MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_d = MEMWB;
         EXECR:  state_d = ALUWB;
         EXECI:  state_d = ALUWB;
         default: state_d = FETCH;
      endcase
   end

   // Raw per-state controls, before condition and reset gating.
   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      reg_w     = 1'b0;
      mem_w     = 1'b0;
      branch    = 1'b0;
      alu_op    = 1'b0;
      case (state_q)
         FETCH: begin
            IRWrite   = reset;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         MEMADR: ALUSrcB = 2'b01;
         MEMRD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_w     = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            mem_w  = 1'b1;
         end
         EXECR: alu_op = 1'b1;
         EXECI: begin
            ALUSrcB = 2'b01;
            alu_op  = 1'b1;
         end
         ALUWB: reg_w = 1'b1;
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ALUControl = 2'b00;
      flag_w     = 2'b00;
      if (alu_op) begin
         case (cmd)
            CMD_ADD: ALUControl = 2'b00;
            CMD_SUB: ALUControl = 2'b01;
            CMD_AND: ALUControl = 2'b10;
            CMD_ORR: ALUControl = 2'b11;
            CMD_CMP: ALUControl = 2'b01;
            default: ALUControl = 2'b00;
         endcase
         flag_w[1] = Funct[0];
         flag_w[0] = Funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
      end
   end

   // NoWrite is taken from the instruction, not the ALU decode, because the
   // register write happens in ALUWB after ALUOp has dropped.
   assign no_write = (Op == 2'b00) & (cmd == CMD_CMP);
   assign pcs      = branch | (reg_w & (Rd == 4'hF));

   assign RegWrite = reset & reg_w & cond_ok_q & ~no_write;
   assign MemWrite = reset & mem_w & cond_ok_q;
   assign PCWrite  = reset & ((state_q == FETCH) | (pcs & cond_ok_q));

   assign ImmSrc = Op;
   assign RegSrc = {Op == 2'b01, Op == 2'b10};
   assign Flags  = flags_q;

   always_comb begin
      flags_d   = flags_q;
      cond_ok_d = (state_q == DECODE) ? cond_ex : cond_ok_q;
      if (flag_w[1] & cond_ok_q) flags_d[3:2] = ALUFlags[3:2];
      if (flag_w[0] & cond_ok_q) flags_d[1:0] = ALUFlags[1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= FETCH;
         flags_q   <= 4'b0000;
         cond_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         flags_q   <= flags_d;
         cond_ok_q <= cond_ok_d;
      end
   end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// tb_arm_multicycle_ctrl: directed and random instruction streams checked
// cycle by cycle against an instruction-level model of the controller.
module tb_arm_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond_i, rd_i, aluflags_i;
   logic [1:0] op_i;
   logic [5:0] funct_i;
   logic [3:0] flags_o;
   logic       pcw, irw, mw, rw, adr, srca;
   logic [1:0] srcb, ress, aluc, imms, regs;

   int errors = 0;
   int checks = 0;
   logic [3:0] mflags;  // model N,Z,C,V

   always #5 clk = ~clk;

   arm_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .Cond(cond_i), .Op(op_i), .Funct(funct_i), .Rd(rd_i),
      .ALUFlags(aluflags_i), .Flags(flags_o), .PCWrite(pcw), .IRWrite(irw),
      .MemWrite(mw), .RegWrite(rw), .AdrSrc(adr), .ALUSrcA(srca), .ALUSrcB(srcb),
      .ResultSrc(ress), .ALUControl(aluc), .ImmSrc(imms), .RegSrc(regs)
   );

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ARM condition: odd codes are the inverse of the even code below them;
   // 1110 is always, so 1111 comes out as never.
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic logic [1:0] alu_model(input logic [3:0] cmd);
      case (cmd)
         4'b0100: return 2'd0;
         4'b0010: return 2'd1;
         4'b0000: return 2'd2;
         4'b1100: return 2'd3;
         4'b1010: return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   // Expected {PCW,IRW,MW,RW,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl} for cycle k.
   function automatic logic [11:0] exp_ctl(input int k, input logic [1:0] op,
                                            input logic [5:0] fn, input logic [3:0] rd,
                                            input logic pass);
      logic p, i, m, r, a, sa;
      logic [1:0] sb, rs, ac;
      {p, i, m, r, a, sa, sb, rs, ac} = 12'b0;
      if (k == 0) begin
         p = 1; i = 1; sa = 1; sb = 2; rs = 2;
      end else if (k == 1) begin
         sa = 1; sb = 2; rs = 2;
      end else begin
         case (op)
            2'b01: begin
               if (k == 2) sb = 1;
               else if (k == 3) begin
                  a = 1;
                  if (!fn[0]) m = pass;
               end else begin
                  rs = 1; r = pass; p = pass && (rd == 4'hF);
               end
            end
            2'b00: begin
               if (k == 2) begin
                  sb = fn[5] ? 2'd1 : 2'd0;
                  ac = alu_model(fn[4:1]);
               end else begin
                  r = pass && (fn[4:1] != 4'b1010);
                  p = pass && (rd == 4'hF);
               end
            end
            2'b10: begin
               sb = 1; rs = 2; p = pass;
            end
            default: ;
         endcase
      end
      return {p, i, m, r, a, sa, sb, rs, ac};
   endfunction

   // Runs one instruction from FETCH; abort_at >= 0 pulls reset in that cycle.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, input logic [3:0] af, input int abort_at);
      int ncyc;
      logic pass;
      logic [3:0] cmd;
      cond_i = c; op_i = op; funct_i = fn; rd_i = rd; aluflags_i = af;
      pass = cond_model(c, mflags);
      cmd  = fn[4:1];
      ncyc = (op == 2'b01) ? (fn[0] ? 5 : 4) : (op == 2'b00) ? 4 : 3;
      for (int k = 0; k < ncyc; k++) begin
         if (k == abort_at) begin
            reset = 1'b0;
            @(negedge clk);
            check("reset_we", {8'b0, pcw, irw, mw, rw}, 12'b0);
            @(posedge clk);
            #1;
            mflags = 4'b0000;
            check("reset_flags", {8'b0, flags_o}, 12'b0);
            reset = 1'b1;
            return;
         end
         @(negedge clk);
         check($sformatf("ctl op%0d k%0d", op, k),
               {pcw, irw, mw, rw, adr, srca, srcb, ress, aluc},
               exp_ctl(k, op, fn, rd, pass));
         check($sformatf("flags k%0d", k), {8'b0, flags_o}, {8'b0, mflags});
         if (k == 0)
            check("imm_regsrc", {8'b0, imms, regs},
                  {8'b0, op, op == 2'b01, op == 2'b10});
         @(posedge clk);
         #1;
         if (k == 2 && op == 2'b00 && fn[0] && pass) begin
            mflags[3:2] = af[3:2];
            if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) mflags[1:0] = af[1:0];
         end
      end
   endtask

   initial begin
      int n;
      logic [5:0] fn;
      reset = 1'b0;
      cond_i = 4'($urandom); op_i = 2'($urandom); funct_i = 6'($urandom);
      rd_i = 4'($urandom); aluflags_i = 4'($urandom);
      mflags = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("init_we", {8'b0, pcw, irw, mw, rw}, 12'b0);
         check("init_flags", {8'b0, flags_o}, 12'b0);
      end
      reset = 1'b1;

      run_instr(4'b1110, 2'b00, 6'b101001, 4'd1, 4'b0110, -1);   // ADDS imm
      run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b1111, -1);   // BEQ taken
      run_instr(4'b1110, 2'b00, 6'b101001, 4'd2, 4'b0000, -1);   // clear Z
      run_instr(4'b0000, 2'b10, 6'b000000, 4'd0, 4'b0100, -1);   // BEQ not taken
      run_instr(4'b1110, 2'b00, 6'b101001, 4'd2, 4'b0110, -1);   // set Z
      run_instr(4'b0001, 2'b01, 6'b011000, 4'd3, 4'b0000, -1);   // STRNE, fails
      run_instr(4'b1110, 2'b00, 6'b010101, 4'd0, 4'b1000, -1);   // CMP
      run_instr(4'b1011, 2'b00, 6'b001000, 4'd4, 4'b0000, -1);   // ADDLT reg
      run_instr(4'b1110, 2'b01, 6'b011001, 4'hF, 4'b0000, -1);   // LDR pc
      run_instr(4'b1110, 2'b01, 6'b011001, 4'hF, 4'b0000, 3);    // LDR, reset in MEMRD
      run_instr(4'b1111, 2'b00, 6'b101001, 4'hF, 4'b1111, -1);   // never
      run_instr(4'b1111, 2'b10, 6'b000000, 4'd0, 4'b1111, -1);
      run_instr(4'b1111, 2'b01, 6'b011000, 4'd0, 4'b1111, -1);
      run_instr(4'b1110, 2'b11, 6'b111111, 4'hF, 4'b1111, -1);   // undefined
      run_instr(4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000, -1);   // STR

      for (int t = 0; t < 80; t++) begin
         fn = 6'($urandom);
         n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
         run_instr(4'($urandom), 2'($urandom), fn, 4'($urandom), 4'($urandom), n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
